// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: shared types and helpers for the data memory arbiter.
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} ArbState;

    localparam int RequesterCount = 2;

    typedef logic ReqId;

    function automatic logic [RequesterCount-1:0] onehot(input ReqId id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_picker.sv
// round_robin_picker: combinational two-way round-robin choice; on a tie the requester
// that did not win last time is picked.
module round_robin_picker
    import data_memory_arbiter_pkg::*;
(
    input  logic [RequesterCount-1:0] req,
    input  ReqId                      last_owner,
    output logic                      valid,
    output ReqId                      winner
);

    assign valid  = |req;
    assign winner = (&req) ? ~last_owner : req[1];

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares the single-port data memory between the CPU (0) and the
// DMA/debug loader (1) with round-robin arbitration and latency-aware read return.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32,
    parameter int MemLatency = 1
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    enable,
    input  logic [RequesterCount-1:0]               req,
    input  logic [RequesterCount-1:0]               reqWrite,
    input  logic [RequesterCount-1:0][AddrWidth-1:0] reqAddr,
    input  logic [RequesterCount-1:0][DataWidth-1:0] reqWData,
    input  logic [RequesterCount-1:0][DataWidth-1:0] reqMask,
    output logic [RequesterCount-1:0]               gnt,
    output logic [RequesterCount-1:0]               rValid,
    output logic [DataWidth-1:0]                    rData,
    output logic                                    busy,
    output logic                                    memWrite,
    output logic [AddrWidth-1:0]                    memAddr,
    output logic [DataWidth-1:0]                    memWData,
    output logic [DataWidth-1:0]                    memWDataMask,
    input  logic [DataWidth-1:0]                    memRData
);

    localparam int CntWidth = (MemLatency > 0) ? $clog2(MemLatency + 1) : 1;

    ArbState              state, state_next;
    ReqId                 last_owner, owner, winner;
    logic                 pick_valid, take, lat_write, capture;
    logic [CntWidth-1:0]  cnt;

    round_robin_picker u_picker (
        .req        (req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (winner)
    );

    // Gating with reset keeps gnt quiet while reset is held.
    assign take    = reset && (state == ARB_IDLE) && enable && pick_valid;
    assign gnt     = take ? onehot(winner) : '0;
    assign rValid  = (state == ARB_RESP) ? onehot(owner) : '0;
    assign busy    = (state != ARB_IDLE);
    assign capture = ((state == ARB_ISSUE) && !lat_write && (MemLatency == 0)) ||
                     ((state == ARB_WAIT) && (cnt == CntWidth'(1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ARB_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE:  state_next = take ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: state_next = lat_write ? ARB_IDLE : (MemLatency == 0 ? ARB_RESP : ARB_WAIT);
            ARB_WAIT:  state_next = (cnt == CntWidth'(1)) ? ARB_RESP : ARB_WAIT;
            ARB_RESP:  state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    // mem* are loaded at the grant edge so the memory sees only registered signals.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_owner   <= 1'b1;
            owner        <= 1'b0;
            lat_write    <= 1'b0;
            cnt          <= '0;
            memWrite     <= 1'b0;
            memAddr      <= '0;
            memWData     <= '0;
            memWDataMask <= '0;
            rData        <= '0;
        end else begin
            memWrite <= take && reqWrite[winner];
            if (take) begin
                last_owner   <= winner;
                owner        <= winner;
                lat_write    <= reqWrite[winner];
                memAddr      <= reqAddr[winner];
                memWData     <= reqWData[winner];
                memWDataMask <= reqMask[winner];
            end
            if (state == ARB_ISSUE)
                cnt <= CntWidth'(MemLatency);
            else if (state == ARB_WAIT)
                cnt <= cnt - CntWidth'(1);
            if (capture)
                rData <= memRData;
        end
    end

endmodule
